// File: rtl/irq_request_latch.sv
// Interrupt request capture ahead of the priority encoder: synchronise, edge/level
// qualify, hold pending under a mask, and run the valid/ack/eoi service handshake.
module irq_request_latch #(
    parameter int N           = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    edge_mode,
    input  logic [N-1:0]    mask_in,
    input  logic            mask_we,
    output logic [N-1:0]    pending_out,
    output logic            irq_valid,
    input  logic            ack,
    input  logic [ID_W-1:0] ack_id,
    input  logic            eoi,
    output logic [N-1:0]    in_service,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   sync_q [SYNC_STAGES];
    logic [N-1:0]   irq_s;
    logic [N-1:0]   irq_s_dly_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   mask_q;
    logic [N-1:0]   mask_d;
    logic [N-1:0]   in_service_q;
    logic [N-1:0]   in_service_d;
    logic [N-1:0]   ack_oh;
    logic [N-1:0]   clr;
    logic           accept;

    assign irq_s       = sync_q[SYNC_STAGES-1];
    assign rise        = irq_s & ~irq_s_dly_q;
    assign pending_out = pend_q & ~mask_q;
    assign in_service  = in_service_q;

    // One-hot decode of ack_id; ids with no matching line decode to zero and are ignored.
    always_comb begin
        ack_oh = '0;
        for (int i = 0; i < N; i++) begin
            ack_oh[i] = (ack_id == ID_W'(i));
        end
    end

    always_comb begin
        accept = ack && (state_q == REQ) && (|(ack_oh & pending_out));
        clr    = accept ? ack_oh : '0;
    end

    // Edge lines: a fresh rise beats a same-cycle ack clear. Level lines track irq_s.
    always_comb begin
        pend_d = (edge_mode & (rise | (pend_q & ~clr))) | (~edge_mode & irq_s);
    end

    always_comb begin
        mask_d = mask_we ? mask_in : mask_q;
    end

    always_comb begin
        in_service_d = in_service_q;
        if (accept) begin
            in_service_d = ack_oh;
        end else if ((state_q == SERVICE) && eoi) begin
            in_service_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            irq_s_dly_q  <= '0;
            pend_q       <= '0;
            mask_q       <= '1;
            in_service_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            irq_s_dly_q  <= irq_s;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|pending_out) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    state_d = SERVICE;
                end else if (!(|pending_out)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_valid = (state_q == REQ);
        busy      = (state_q == SERVICE);
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: stimulus queues expected outputs, a monitor
// compares them against the DUT on the falling edge.
module tb_irq_request_latch;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] edge_mode;
    logic [7:0] mask_in;
    logic       mask_we;
    logic [7:0] pending_out;
    logic       irq_valid;
    logic       ack;
    logic [2:0] ack_id;
    logic       eoi;
    logic [7:0] in_service;
    logic       busy;

    typedef struct {
        string      name;
        logic [7:0] pend;
        logic       valid;
        logic       busy;
        logic [7:0] insvc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    irq_request_latch #(.N(8), .ID_W(3), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .edge_mode   (edge_mode),
        .mask_in     (mask_in),
        .mask_we     (mask_we),
        .pending_out (pending_out),
        .irq_valid   (irq_valid),
        .ack         (ack),
        .ack_id      (ack_id),
        .eoi         (eoi),
        .in_service  (in_service),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every queued expectation is checked at the following falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({pending_out, irq_valid, busy, in_service} !== {e.pend, e.valid, e.busy, e.insvc}) begin
                errors++;
                $display("FAIL %s: got pend=%h valid=%b busy=%b insvc=%h, expected pend=%h valid=%b busy=%b insvc=%h",
                         e.name, pending_out, irq_valid, busy, in_service, e.pend, e.valid, e.busy, e.insvc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] p, input logic v,
                              input logic b, input logic [7:0] s);
        exp_t e;
        e.name  = name;
        e.pend  = p;
        e.valid = v;
        e.busy  = b;
        e.insvc = s;
        sb.push_back(e);
    endtask

    task automatic do_ack(input logic [2:0] id);
        ack    = 1'b1;
        ack_id = id;
        tick(1);
        ack    = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        irq_in    = 8'h00;
        edge_mode = 8'hFF;
        mask_in   = 8'h00;
        mask_we   = 1'b0;
        ack       = 1'b0;
        ack_id    = 3'd0;
        eoi       = 1'b0;
        tick(2);
        rst = 1'b0;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 8'h00);

        // 1: edge request on line 2, latency to pending_out and irq_valid
        mask_in = 8'h00; mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        irq_in  = 8'h04;
        tick(2);
        expect_out("t1_before_pend", 8'h00, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t1_pend", 8'h04, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t1_valid", 8'h04, 1'b1, 1'b0, 8'h00);
        do_ack(3'd2);
        expect_out("t1_ack", 8'h00, 1'b0, 1'b1, 8'h04);
        do_eoi();
        expect_out("t1_eoi", 8'h00, 1'b0, 1'b0, 8'h00);
        irq_in = 8'h00;
        tick(4);

        // 2: simultaneous lines 7 and 0, service 7, re-request after eoi
        irq_in = 8'h81;
        tick(3);
        expect_out("t2_pend", 8'h81, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t2_valid", 8'h81, 1'b1, 1'b0, 8'h00);
        do_ack(3'd7);
        expect_out("t2_ack7", 8'h01, 1'b0, 1'b1, 8'h80);
        do_eoi();
        expect_out("t2_eoi_idle", 8'h01, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t2_rereq", 8'h01, 1'b1, 1'b0, 8'h00);
        do_ack(3'd0);
        do_eoi();
        irq_in = 8'h00;
        tick(4);
        expect_out("t2_idle", 8'h00, 1'b0, 1'b0, 8'h00);

        // 3: masked edge is retained and released on unmask
        mask_in = 8'hFF; mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        irq_in  = 8'h08;
        tick(1);
        irq_in  = 8'h00;
        tick(4);
        expect_out("t3_masked", 8'h00, 1'b0, 1'b0, 8'h00);
        mask_in = 8'h00; mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        expect_out("t3_unmask", 8'h08, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t3_valid", 8'h08, 1'b1, 1'b0, 8'h00);
        do_ack(3'd3);
        do_eoi();
        tick(2);
        expect_out("t3_idle", 8'h00, 1'b0, 1'b0, 8'h00);

        // 4: level mode on line 5
        edge_mode = 8'hDF;
        irq_in    = 8'h20;
        tick(3);
        expect_out("t4_pend", 8'h20, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t4_valid", 8'h20, 1'b1, 1'b0, 8'h00);
        do_ack(3'd5);
        expect_out("t4_ack_keeps", 8'h20, 1'b0, 1'b1, 8'h20);
        do_eoi();
        expect_out("t4_eoi", 8'h20, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t4_rereq", 8'h20, 1'b1, 1'b0, 8'h00);
        irq_in = 8'h00;
        tick(2);
        expect_out("t4_drop_hold", 8'h20, 1'b1, 1'b0, 8'h00);
        tick(1);
        expect_out("t4_drop", 8'h00, 1'b1, 1'b0, 8'h00);
        tick(1);
        expect_out("t4_back_idle", 8'h00, 1'b0, 1'b0, 8'h00);
        edge_mode = 8'hFF;
        tick(2);

        // 5: illegal handshakes in REQ, then ack+eoi together
        irq_in = 8'h02;
        tick(4);
        expect_out("t5_valid", 8'h02, 1'b1, 1'b0, 8'h00);
        do_ack(3'd4);
        expect_out("t5_bad_ack", 8'h02, 1'b1, 1'b0, 8'h00);
        do_eoi();
        expect_out("t5_eoi_in_req", 8'h02, 1'b1, 1'b0, 8'h00);
        ack = 1'b1; ack_id = 3'd1; eoi = 1'b1;
        tick(1);
        expect_out("t5_ack_with_eoi", 8'h00, 1'b0, 1'b1, 8'h02);
        tick(1);
        ack = 1'b0; eoi = 1'b0;
        expect_out("t5_eoi_with_ack", 8'h00, 1'b0, 1'b0, 8'h00);
        irq_in = 8'h00;
        tick(4);

        // 6: new edge on line 2 lands in the ack cycle, then reset during service
        irq_in = 8'h04;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        irq_in = 8'h04;
        tick(1);
        expect_out("t6_pend", 8'h04, 1'b0, 1'b0, 8'h00);
        tick(1);
        expect_out("t6_valid", 8'h04, 1'b1, 1'b0, 8'h00);
        do_ack(3'd2);
        expect_out("t6_set_wins", 8'h04, 1'b0, 1'b1, 8'h04);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_out("t6_reset", 8'h00, 1'b0, 1'b0, 8'h00);
        tick(4);
        expect_out("t6_mask_all", 8'h00, 1'b0, 1'b0, 8'h00);
        mask_in = 8'h00; mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        expect_out("t6_unmask", 8'h04, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
